// File: rtl/picoblaze_int_ctrl.sv
// picoblaze_int_ctrl: edge-captured, masked, fixed-priority interrupt controller with KCPSM6 port registers
module picoblaze_int_ctrl #(
  parameter int N_SRC = 8,
  parameter logic [7:0] PORT_STATUS = 8'h10,
  parameter logic [7:0] PORT_MASK = 8'h11,
  parameter logic [7:0] PORT_ACK = 8'h12,
  parameter logic [7:0] PORT_VECTOR = 8'h13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             k_write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  input  logic             interrupt_ack,
  output logic             interrupt,
  output logic [7:0]       rd_data,
  output logic             rd_hit
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_nxt;
  logic [N_SRC-1:0] src_q, pend, mask, rise, act, ack_clr;
  logic [2:0] vec_idx, vec_nxt, low;
  logic [7:0] pend8, mask8, vec_reg;
  logic wr, unused_rd;
  assign unused_rd = read_strobe;
  assign wr = write_strobe | k_write_strobe;
  assign rise = irq_src & ~src_q;
  assign act = pend & mask;
  assign ack_clr = (wr && port_id == PORT_ACK) ? out_port[N_SRC-1:0] : '0;
  assign pend8 = 8'(pend);
  assign mask8 = 8'(mask);
  assign vec_reg = {state != IDLE, 4'b0, vec_idx};
  always_comb begin
    low = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (act[i]) low = 3'(i);
  end
  // vec_idx is zeroed on every return to IDLE so an idle VECTOR read is 8'h00
  always_comb begin
    state_nxt = state;
    vec_nxt = vec_idx;
    case (state)
      IDLE: if (act != '0) begin
        state_nxt = REQ;
        vec_nxt = low;
      end
      REQ: if (interrupt_ack) state_nxt = SERVICE;
        else if (act == '0) begin
          state_nxt = IDLE;
          vec_nxt = '0;
        end
      SERVICE: if (!pend8[vec_idx]) begin
        state_nxt = IDLE;
        vec_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        vec_nxt = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    src_q <= irq_src;
    if (!reset) begin
      pend <= '0;
      mask <= '0;
      vec_idx <= '0;
      state <= IDLE;
      interrupt <= 1'b0;
      rd_data <= '0;
      rd_hit <= 1'b0;
    end else begin
      pend <= (pend & ~ack_clr) | rise;
      mask <= (wr && port_id == PORT_MASK) ? out_port[N_SRC-1:0] : mask;
      vec_idx <= vec_nxt;
      state <= state_nxt;
      interrupt <= state_nxt == REQ;
      rd_data <= port_id == PORT_STATUS ? pend8 :
                 port_id == PORT_MASK   ? mask8 :
                 port_id == PORT_VECTOR ? vec_reg : 8'h00;
      rd_hit <= port_id == PORT_STATUS || port_id == PORT_MASK ||
                port_id == PORT_ACK || port_id == PORT_VECTOR;
    end
  end
endmodule

// File: doc/picoblaze_int_ctrl.md
# picoblaze_int_ctrl

- Multi-source interrupt controller and I/O-mapped register block for the KCPSM6 microcontroller subsystem.
- Captures rising edges on up to 8 peripheral interrupt sources and masks them, then arbitrates the active ones by fixed priority.
- Drives the processor's single `interrupt` line and completes the `interrupt_ack` handshake.
- Exposes status, mask, acknowledge and vector registers on the processor's `port_id` / `write_strobe` / `read_strobe` bus.

## Interface
- `N_SRC`, 8: number of interrupt sources, 1..8.
- `PORT_STATUS`, 8'h10: read address of the pending register.
- `PORT_MASK`, 8'h11: read/write address of the enable mask.
- `PORT_ACK`, 8'h12: write-1-to-clear address for pending bits.
- `PORT_VECTOR`, 8'h13: read address of the vector register.
- `clk` input 1: single system clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `irq_src` input N_SRC: peripheral interrupt levels, synchronous to `clk`. Only a rising edge is an event.
- `port_id` input 8: processor port address.
- `write_strobe` input 1: OUTPUT strobe.
- `k_write_strobe` input 1: OUTPUTK strobe. Treated identically to `write_strobe`.
- `read_strobe` input 1: INPUT strobe. Informational only; reads have no side effects.
- `out_port` input 8: processor write data.
- `interrupt_ack` input 1: processor interrupt acknowledge.
- `interrupt` output 1: interrupt request to the processor.
- `rd_data` output 8: registered read data, muxed onto the processor `in_port` upstream.
- `rd_hit` output 1: registered. 1 when the sampled `port_id` matches any of the four addresses.

## Operation
- Edge detect:
  - `src_q <= irq_src` every cycle.
  - `rise = irq_src & ~src_q`.
  - During reset, `src_q` loads `irq_src`, so sources already high at reset exit do not fire.
- Pending register (`pend`, N_SRC bits):
  - Bit i sets on `rise[i]`.
  - Bit i clears when a write to `PORT_ACK` has `out_port[i]=1`.
  - Set and clear in the same cycle: set wins.
- Mask register:
  - Written from `out_port[N_SRC-1:0]` on a write to `PORT_MASK`.
  - Reset value 0, all sources disabled.
- Active vector: `act = pend & mask`. Priority: lowest index wins.
- State machine, reset state IDLE:
  - IDLE: if `act != 0`, latch `vec_idx` = lowest set bit of `act` and go to REQ. Otherwise stay.
  - REQ: `interrupt=1`. If `interrupt_ack`, go to SERVICE. If `act == 0` without an ack (cleared or masked by software), go to IDLE and drop `interrupt`.
  - SERVICE: `interrupt=0`. Go to IDLE once `pend[vec_idx]==0`. Other sources keep accumulating in `pend`.
- `interrupt` is a registered decode of the state: 1 only in REQ.
- Vector register read: `{busy, 4'b0, vec_idx[2:0]}`, where `busy = (state != IDLE)`.
- Read mux, registered every cycle from the current `port_id`:
  - STATUS returns `pend`.
  - MASK returns `mask`.
  - VECTOR returns the vector register.
  - ACK and unmapped addresses return 8'h00.
  - Unused upper bits are 0.
- Writes to STATUS or VECTOR are ignored.
- Reset values: `pend=0`, `mask=0`, `vec_idx=0`, state IDLE, `interrupt=0`, `rd_data=0`, `rd_hit=0`.
- Reset mid-operation: returns to the reset values on the next edge, regardless of state or handshake in progress.

## Timing
- `irq_src[i]` rises before edge k → `pend[i]=1` after edge k → state REQ and `interrupt=1` after edge k+1, if unmasked. Two-cycle latency.
- `interrupt_ack` high before edge a → `interrupt=0` after edge a.
- ACK write before edge w → `pend` bit clear after w → IDLE after w+1 → REQ for the next active source after w+2.
- `rd_data` is valid one cycle after `port_id`. KCPSM6 holds `port_id` for 2 cycles, so data is valid while `read_strobe` is high.
- Mask write before edge m: new mask takes effect in the arbitration at edge m+1.

## Test plan
- Reset and read-back:
  - Stimulus: hold `reset=0` for 3 cycles, then read all four ports.
  - Required: `interrupt=0`; STATUS, MASK and VECTOR all read 8'h00.
- Single source round trip:
  - Stimulus: mask=8'h04, pulse `irq_src[2]`.
  - Required: `interrupt=1` exactly 2 cycles after the rise; `interrupt_ack` drops it; VECTOR=8'h82; writing ACK 8'h04 clears STATUS to 0; VECTOR=8'h00 two cycles later.
- Priority:
  - Stimulus: mask=8'hFF, rise sources 5 and 1 in the same cycle.
  - Required: `vec_idx=1`. After ack and clear of bit 1, a second `interrupt` follows with VECTOR=8'h85.
- Masked and held sources:
  - Stimulus: mask=0, rise source 3. Separately, hold a source high through reset.
  - Required: STATUS=8'h08 and `interrupt` stays 0; setting mask=8'h08 raises `interrupt` 2 cycles after the write. The source held high through reset sets no pending bit.
- Set/clear collision:
  - Stimulus: ACK write of bit 0 in the same cycle as a new `rise[0]`.
  - Required: `pend[0]` remains 1.
- Withdraw and reset during the handshake:
  - Stimulus: in REQ, write mask=0; in a separate run, assert `reset` in SERVICE.
  - Required: the mask write drops `interrupt` and returns to IDLE without an ack. The reset returns everything to the reset values after one edge.
